ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction fetch controller between the PC register and a wait-state instruction memory bus.
- Takes the current PC and issues one request/grant/response transaction per instruction.
- Delivers the instruction with its PC to decode.
- Drives pc_stall so the next-PC path holds PC until the instruction is delivered. Discards responses made stale by a redirect, and flags misaligned PCs and bus timeouts.

Parameters:
- ADDR_W, 32, PC / bus address width.
- DATA_W, 32, instruction width.
- TIMEOUT, 255, max cycles in any bus-wait state before fault (8-bit counter).
- NOP_INSTR, 32'h00000013, instruction value held on reset (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  core run enable
- pc  in  ADDR_W  current PC from PC register
- redirect  in  1  PC being overwritten out-of-band (trap/debug); in-flight fetch is stale
- imem_req  out  1  bus request
- imem_addr  out  ADDR_W  request address, stable while imem_req=1
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  DATA_W  response data
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  one-cycle pulse: instr/instr_pc new
- pc_stall  out  1  hold PC; combinational = ~instr_valid
- fetch_fault  out  1  sticky fault flag

Behaviour:
- Clock: clk. Reset: reset, asynchronous, active-high.
- Reset values:
  - state IDLE
  - imem_req=0, imem_addr=0
  - instr=NOP_INSTR, instr_pc=0, instr_valid=0
  - pc_stall=1, fetch_fault=0
  - wait_cnt=0
- States: IDLE, REQ, WAIT, DROP. All outputs registered except pc_stall.
- IDLE:
  - Issue only when fetch_en=1, instr_valid=0 and fetch_fault=0.
  - If pc[1:0]≠0: fetch_fault<=1, stay IDLE, no request.
  - Else: imem_addr<=pc, imem_req<=1, go REQ.
  - redirect ignored in IDLE.
  - imem_rvalid ignored in IDLE (covers stray responses after reset).
- REQ:
  - imem_req and imem_addr held until imem_gnt.
  - On gnt: imem_req<=0; go DROP if redirect was seen this cycle or earlier in REQ (sticky drop_pending), else WAIT.
  - imem_rvalid ignored in REQ; the response is at least one cycle after gnt.
- WAIT:
  - imem_rvalid && !redirect: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1 for exactly one cycle, go IDLE.
  - imem_rvalid && redirect: discard, go IDLE.
  - redirect without rvalid: go DROP.
- DROP: on imem_rvalid, discard data, go IDLE. No instr_valid.
- Latency: request→deliver minimum 3 cycles (REQ, WAIT with rvalid, instr_valid in IDLE). Next issue is one cycle after the instr_valid cycle, when PC has advanced.
- pc_stall low only during the instr_valid cycle; PC register loads PCNext at that edge.
- fetch_en deasserted mid-transaction: the transaction completes and the instruction is delivered; no new issue.
- Timeout:
  - wait_cnt clears on entry to REQ/WAIT/DROP and increments each cycle in those states, saturating.
  - Reaching TIMEOUT: fetch_fault<=1, imem_req<=0, go IDLE.
- fetch_fault: sticky until reset; it blocks all further issues.
- Reset mid-transaction: immediate return to reset values; any later response is ignored.
- instr/instr_pc hold their last value between pulses.

Decomposition:
- Shared package (core_pkg):
  - ADDR_W, DATA_W
  - NOP_INSTR
  - state encoding typedef (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DROP=2'd3)
- Sub-module fetch_timeout_ctr:
  - 8-bit saturating counter with clear/enable and expired output, threshold TIMEOUT.
  - Reused later for data-memory access.

Test Plan:
- Zero-wait fetch: reset, fetch_en=1, pc=0, gnt same cycle as req, rvalid next cycle with data 0x00500093 → instr_valid pulse with instr=0x00500093, instr_pc=0; pc_stall low only that cycle; next req imem_addr=4.
- Wait states: gnt delayed 3 cycles, rvalid 5 cycles after gnt → imem_req and imem_addr stable throughout; single instr_valid; instr_pc=imem_addr.
- Redirect in WAIT: redirect pulse 1 cycle after gnt, rvalid 2 cycles later with 0xDEADBEEF → no instr_valid, instr unchanged. Next fetch uses the new pc=0x100 and delivers normally.
- Misaligned PC: pc=0x00000006 in IDLE → fetch_fault=1 next cycle, imem_req never asserted, fault persists until reset.
- Timeout: gnt given, rvalid never → fetch_fault=1 exactly TIMEOUT cycles after entering WAIT; imem_req=0; later rvalid ignored.
- Reset mid-WAIT: assert reset asynchronously → outputs at reset values immediately; rvalid after release → no instr_valid.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared widths, reset instruction and fetch FSM encoding
// Rev 1.0
// ============================================================================
package core_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// ifetch_ctrl_if : instruction-memory request/grant/response bus
// Rev 1.0
// ============================================================================
interface ifetch_ctrl_if #(
  parameter int ADDR_W = core_pkg::ADDR_W,
  parameter int DATA_W = core_pkg::DATA_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
// fetch_timeout_ctr : 8-bit saturating bus-wait counter with expiry flag
// Rev 1.0
// ============================================================================
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expired
);

  localparam int         CNT_W  = 8;
  localparam logic [7:0] C_MAX  = 8'hFF;
  localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expires in the cycle whose increment would reach TIMEOUT, so the owner's
  // registered reaction lands exactly TIMEOUT cycles after the clear.
  assign o_expired = i_en && (r_cnt >= C_LAST);

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// ifetch_ctrl : one-transaction-per-instruction fetch controller with PC stall
// Rev 1.0
// ============================================================================
module ifetch_ctrl #(
  parameter int               ADDR_W    = core_pkg::ADDR_W,
  parameter int               DATA_W    = core_pkg::DATA_W,
  parameter int               TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              fetch_en,
  input  wire logic [ADDR_W-1:0] pc,
  input  wire logic              redirect,
  ifetch_ctrl_if.master          imem,
  output logic      [DATA_W-1:0] instr,
  output logic      [ADDR_W-1:0] instr_pc,
  output logic                   instr_valid,
  output logic                   pc_stall,
  output logic                   fetch_fault
);

  import core_pkg::*;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;

  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_fault;
  logic              r_drop_pend;

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_instr;
  logic [ADDR_W-1:0] w_instr_pc;
  logic              w_instr_valid;
  logic              w_fault;
  logic              w_drop_pend;

  logic              w_issue;
  logic              w_misaligned;
  logic              w_ctr_clr;
  logic              w_ctr_en;
  logic              w_expired;

  assign w_issue      = fetch_en && !r_instr_valid && !r_fault;
  assign w_misaligned = is_misaligned(pc);

  // Wait counter restarts on every state change into a bus-wait state.
  assign w_ctr_clr = (w_state_nxt != r_state);
  assign w_ctr_en  = (r_state != IDLE);

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_ctr_clr),
    .i_en      (w_ctr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus progress (grant/response) takes priority over an expiring counter.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_issue && !w_misaligned) w_state_nxt = REQ;
      end
      REQ: begin
        if (imem.imem_gnt)  w_state_nxt = (redirect || r_drop_pend) ? DROP : WAIT;
        else if (w_expired) w_state_nxt = IDLE;
      end
      WAIT: begin
        if (imem.imem_rvalid) w_state_nxt = IDLE;
        else if (redirect)    w_state_nxt = DROP;
        else if (w_expired)   w_state_nxt = IDLE;
      end
      DROP: begin
        if (imem.imem_rvalid || w_expired) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req         = r_req;
    w_addr        = r_addr;
    w_instr       = r_instr;
    w_instr_pc    = r_instr_pc;
    w_instr_valid = 1'b0;
    w_fault       = r_fault;
    w_drop_pend   = r_drop_pend;
    case (r_state)
      IDLE: begin
        w_drop_pend = 1'b0;
        if (w_issue) begin
          if (w_misaligned) begin
            w_fault = 1'b1;
          end else begin
            w_req  = 1'b1;
            w_addr = pc;
          end
        end
      end
      REQ: begin
        if (redirect) w_drop_pend = 1'b1;
        if (imem.imem_gnt) begin
          w_req = 1'b0;
        end else if (w_expired) begin
          w_req   = 1'b0;
          w_fault = 1'b1;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (!redirect) begin
            w_instr       = imem.imem_rdata;
            w_instr_pc    = r_addr;
            w_instr_valid = 1'b1;
          end
        end else if (!redirect && w_expired) begin
          w_fault = 1'b1;
        end
      end
      DROP: begin
        if (!imem.imem_rvalid && w_expired) w_fault = 1'b1;
      end
      default: begin
        w_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req         <= 1'b0;
      r_addr        <= '0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_drop_pend   <= 1'b0;
    end else begin
      r_req         <= w_req;
      r_addr        <= w_addr;
      r_instr       <= w_instr;
      r_instr_pc    <= w_instr_pc;
      r_instr_valid <= w_instr_valid;
      r_fault       <= w_fault;
      r_drop_pend   <= w_drop_pend;
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_valid    = r_instr_valid;
  assign fetch_fault    = r_fault;
  assign pc_stall       = ~r_instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ifetch_ctrl : directed self-checking bench for ifetch_ctrl
// Rev 1.0
// ============================================================================
module tb_ifetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        pc_stall;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  ifetch_ctrl_if bus ();

  ifetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .redirect    (redirect),
    .imem        (bus),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .pc_stall    (pc_stall),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   64'(bus.imem_req),  64'd0);
    chk({tag, "_addr"},  64'(bus.imem_addr), 64'd0);
    chk({tag, "_instr"}, 64'(instr),         64'(NOP));
    chk({tag, "_ipc"},   64'(instr_pc),      64'd0);
    chk({tag, "_valid"}, 64'(instr_valid),   64'd0);
    chk({tag, "_stall"}, 64'(pc_stall),      64'd1);
    chk({tag, "_fault"}, 64'(fetch_fault),   64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    fetch_en        = 1'b0;
    pc              = 32'h0;
    redirect        = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // zero-wait fetch at pc=0
    fetch_en = 1'b1;
    tick();
    chk("zw_req",  64'(bus.imem_req),  64'd1);
    chk("zw_addr", 64'(bus.imem_addr), 64'h0);
    bus.imem_gnt = 1'b1;
    tick();
    chk("zw_req_drop", 64'(bus.imem_req), 64'd0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    tick();
    chk("zw_valid", 64'(instr_valid), 64'd1);
    chk("zw_instr", 64'(instr),       64'h0050_0093);
    chk("zw_ipc",   64'(instr_pc),    64'h0);
    chk("zw_stall", 64'(pc_stall),    64'd0);
    bus.imem_rvalid = 1'b0;
    pc = 32'h4;
    tick();
    chk("zw_valid_off", 64'(instr_valid), 64'd0);
    chk("zw_stall_on",  64'(pc_stall),    64'd1);
    chk("zw_no_issue",  64'(bus.imem_req), 64'd0);
    tick();
    chk("zw_next_req",  64'(bus.imem_req),  64'd1);
    chk("zw_next_addr", 64'(bus.imem_addr), 64'h4);

    // wait states: grant after 3 cycles, response 5 cycles after grant
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_req_hold",  64'(bus.imem_req),  64'd1);
      chk("ws_addr_hold", 64'(bus.imem_addr), 64'h4);
    end
    bus.imem_gnt = 1'b1;
    tick();
    chk("ws_req_drop", 64'(bus.imem_req), 64'd0);
    bus.imem_gnt = 1'b0;
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ws_no_valid", 64'(instr_valid), 64'd0);
      chk("ws_stall",    64'(pc_stall),    64'd1);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00A0_0113;
    tick();
    chk("ws_valid", 64'(instr_valid), 64'd1);
    chk("ws_instr", 64'(instr),       64'h00A0_0113);
    chk("ws_ipc",   64'(instr_pc),    64'h4);
    bus.imem_rvalid = 1'b0;
    pc = 32'h8;
    tick();
    chk("ws_single_pulse", 64'(instr_valid),  64'd0);
    chk("ws_en_off_req",   64'(bus.imem_req), 64'd0);
    tick();
    chk("ws_en_off_req2",  64'(bus.imem_req), 64'd0);
    fetch_en = 1'b1;
    tick();
    chk("rd_req",  64'(bus.imem_req),  64'd1);
    chk("rd_addr", 64'(bus.imem_addr), 64'h8);

    // redirect one cycle after grant: response discarded
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    redirect     = 1'b1;
    pc           = 32'h100;
    tick();
    redirect = 1'b0;
    tick();
    chk("rd_wait_valid", 64'(instr_valid), 64'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("rd_discard_valid", 64'(instr_valid), 64'd0);
    chk("rd_instr_kept",    64'(instr),       64'h00A0_0113);
    chk("rd_ipc_kept",      64'(instr_pc),    64'h4);
    bus.imem_rvalid = 1'b0;
    tick();
    chk("rd_new_req",  64'(bus.imem_req),  64'd1);
    chk("rd_new_addr", 64'(bus.imem_addr), 64'h100);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1234_5678;
    tick();
    chk("rd_deliver_valid", 64'(instr_valid), 64'd1);
    chk("rd_deliver_instr", 64'(instr),       64'h1234_5678);
    chk("rd_deliver_ipc",   64'(instr_pc),    64'h100);
    bus.imem_rvalid = 1'b0;
    pc = 32'h104;
    tick();
    tick();
    chk("rq_addr", 64'(bus.imem_addr), 64'h104);

    // redirect while still in REQ: grant later, response dropped
    redirect = 1'b1;
    tick();
    chk("rq_req_hold", 64'(bus.imem_req), 64'd1);
    redirect     = 1'b0;
    pc           = 32'h200;
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0BAD;
    tick();
    chk("rq_drop_valid", 64'(instr_valid), 64'd0);
    chk("rq_drop_instr", 64'(instr),       64'h1234_5678);
    bus.imem_rvalid = 1'b0;
    tick();
    chk("to_addr", 64'(bus.imem_addr), 64'h200);

    // timeout: grant, never respond
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    repeat (254) tick();
    chk("to_not_yet", 64'(fetch_fault), 64'd0);
    tick();
    chk("to_fault", 64'(fetch_fault),  64'd1);
    chk("to_req",   64'(bus.imem_req), 64'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hFFFF_FFFF;
    tick();
    chk("to_late_valid", 64'(instr_valid), 64'd0);
    chk("to_late_instr", 64'(instr),       64'h1234_5678);
    bus.imem_rvalid = 1'b0;
    repeat (3) tick();
    chk("to_sticky",   64'(fetch_fault),  64'd1);
    chk("to_no_issue", 64'(bus.imem_req), 64'd0);

    // misaligned PC
    #2;
    reset = 1'b1;
    #1;
    chk("mis_rst_fault", 64'(fetch_fault), 64'd0);
    #2;
    reset = 1'b0;
    pc = 32'h6;
    tick();
    chk("mis_fault", 64'(fetch_fault),  64'd1);
    chk("mis_noreq", 64'(bus.imem_req), 64'd0);
    pc = 32'h8;
    repeat (3) tick();
    chk("mis_sticky",   64'(fetch_fault),  64'd1);
    chk("mis_blocked",  64'(bus.imem_req), 64'd0);

    // asynchronous reset in the middle of WAIT
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    pc = 32'h40;
    tick();
    chk("ar_req",  64'(bus.imem_req),  64'd1);
    chk("ar_addr", 64'(bus.imem_addr), 64'h40);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("ar");
    fetch_en = 1'b0;
    #2;
    reset = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_CAFE;
    tick();
    chk("ar_late_valid", 64'(instr_valid), 64'd0);
    chk("ar_late_instr", 64'(instr),       64'(NOP));
    bus.imem_rvalid = 1'b0;
    tick();
    chk("ar_idle_req", 64'(bus.imem_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
